// File: rtl/fp_max_tracker_if.sv
// -----------------------------------------------------------------------------
// fp_max_tracker_if
//   Bundles the sample input stream and the frame-maximum result stream of
//   fp_max_tracker.
//
//   Handshake rule (both directions): a transfer happens on a rising clk edge
//   where valid and ready are both 1. A source that raises valid keeps valid
//   and its payload unchanged until that transfer happens. The sink may drive
//   ready independently of valid.
//
//   Signals
//     in_valid / in_ready          sample stream handshake
//     in_sign, in_exp, in_frac     sample payload (sign 1 = negative)
//     out_valid / out_ready        result stream handshake
//     max_sign, max_exp, max_frac  frame maximum payload
//     max_idx                      position of the maximum within the frame
//                                  (only with FP_MAX_IDX_EN defined)
//
//   Modports
//     master : the producer of samples / consumer of results
//     slave  : fp_max_tracker itself
// -----------------------------------------------------------------------------
interface fp_max_tracker_if #(
  parameter int EXP_W  = 4,
  parameter int FRAC_W = 9
`ifdef FP_MAX_IDX_EN
  , parameter int IDX_W = 4
`endif
);

  logic              in_valid;
  logic              in_ready;
  logic              in_sign;
  logic [EXP_W-1:0]  in_exp;
  logic [FRAC_W-1:0] in_frac;

  logic              out_valid;
  logic              out_ready;
  logic              max_sign;
  logic [EXP_W-1:0]  max_exp;
  logic [FRAC_W-1:0] max_frac;
`ifdef FP_MAX_IDX_EN
  logic [IDX_W-1:0]  max_idx;
`endif

  modport master (
    output in_valid, in_sign, in_exp, in_frac, out_ready,
    input  in_ready, out_valid, max_sign, max_exp, max_frac
`ifdef FP_MAX_IDX_EN
    , input max_idx
`endif
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_frac, out_ready,
    output in_ready, out_valid, max_sign, max_exp, max_frac
`ifdef FP_MAX_IDX_EN
    , output max_idx
`endif
  );

endinterface

// File: rtl/fp_max_tracker.sv
// -----------------------------------------------------------------------------
// fp_max_tracker
//   Consumes frames of FRAME_LEN sign/exponent/fraction samples and reports
//   the largest sample of each frame. Ordering: the positive value of a
//   differently-signed pair is larger (+0 > -0); among positives the larger
//   {exp,frac} magnitude wins, among negatives the smaller one wins. On a tie
//   the earlier sample is kept.
//
//   Optional feature macro: FP_MAX_IDX_EN
//     defined   -> bus.max_idx carries the 0-based frame position of the
//                  winning sample.
//     undefined -> no index port or register.
//
//   Ports
//     clk        rising-edge clock
//     reset      asynchronous, active-high
//     clear      synchronous frame abort back to IDLE (beats accept/out_ready)
//     bus        fp_max_tracker_if.slave: sample in, frame maximum out
//     dbg_state  current FSM state (0 IDLE, 1 ACCUM, 2 DONE)
// -----------------------------------------------------------------------------
module fp_max_tracker #(
  parameter int FRAME_LEN = 16,
  parameter int EXP_W     = 4,
  parameter int FRAC_W    = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  fp_max_tracker_if.slave      bus,
  output logic [1:0]           dbg_state
);

  localparam int MAG_W = EXP_W + FRAC_W;
  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);
`ifdef FP_MAX_IDX_EN
  localparam int IDX_W = $clog2(FRAME_LEN);
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [CNT_W-1:0]  count_q;
  logic              max_sign_q;
  logic [MAG_W-1:0]  max_mag_q;
`ifdef FP_MAX_IDX_EN
  logic [IDX_W-1:0]  max_idx_q;
`endif

  logic              in_ready_c;
  logic              out_valid_c;
  logic              accept;
  logic              load_first;
  logic              replace;
  logic [MAG_W-1:0]  in_mag;

  // Strict "a greater than b". Equal values (including identical zeros)
  // give 0, which is what makes ties keep the earlier sample.
  function automatic logic gt(input logic             a_sign,
                              input logic [MAG_W-1:0] a_mag,
                              input logic             b_sign,
                              input logic [MAG_W-1:0] b_mag);
    logic r;
    if (a_sign != b_sign) begin
      r = b_sign;            // a is the positive one exactly when b is negative
    end else if (!a_sign) begin
      r = (a_mag > b_mag);
    end else begin
      r = (a_mag < b_mag);   // negatives: smaller magnitude is larger value
    end
    return r;
  endfunction

  assign in_mag = {bus.in_exp, bus.in_frac};
  assign accept = bus.in_valid & in_ready_c;

  // clear wins over an accept in the same cycle, so no register loads then.
  assign load_first = accept & ~clear & (state_q == IDLE);
  assign replace    = accept & ~clear & (state_q == ACCUM) &
                      gt(bus.in_sign, in_mag, max_sign_q, max_mag_q);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) state_d = ACCUM;
        end
        ACCUM: begin
          // The accept that brings the count to FRAME_LEN closes the frame.
          if (accept && (count_q == LAST_CNT)) state_d = DONE;
        end
        DONE: begin
          if (bus.out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (Moore; input side stalls only while a result is pending)
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready_c  = 1'b1;
    out_valid_c = 1'b0;
    case (state_q)
      IDLE:    begin in_ready_c = 1'b1; out_valid_c = 1'b0; end
      ACCUM:   begin in_ready_c = 1'b1; out_valid_c = 1'b0; end
      DONE:    begin in_ready_c = 1'b0; out_valid_c = 1'b1; end
      default: begin in_ready_c = 1'b1; out_valid_c = 1'b0; end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sample counter: number of samples accepted in the current frame
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else begin
      case (state_q)
        IDLE:    if (accept)        count_q <= CNT_W'(1);
        ACCUM:   if (accept)        count_q <= count_q + CNT_W'(1);
        DONE:    if (bus.out_ready) count_q <= '0;
        default:                    count_q <= '0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Running maximum. The first sample of a frame loads unconditionally so the
  // previous frame's result never leaks into the comparison.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      max_sign_q <= 1'b0;
      max_mag_q  <= '0;
    end else if (load_first || replace) begin
      max_sign_q <= bus.in_sign;
      max_mag_q  <= in_mag;
    end
  end

`ifdef FP_MAX_IDX_EN
  // count_q equals the 0-based position of the sample being accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      max_idx_q <= '0;
    end else if (load_first) begin
      max_idx_q <= '0;
    end else if (replace) begin
      max_idx_q <= count_q[IDX_W-1:0];
    end
  end

  assign bus.max_idx = max_idx_q;
`endif

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.max_sign  = max_sign_q;
  assign bus.max_exp   = max_mag_q[MAG_W-1:FRAC_W];
  assign bus.max_frac  = max_mag_q[FRAC_W-1:0];
  assign dbg_state     = state_q;

endmodule
